// File: rtl/op_dispatcher_pkg.sv
// Shared op type, command encodings and dispatcher enums for op_dispatcher
// and its command decoder.
package Op_PKG;

  localparam int unsigned OP_CMD_W = 8;
  localparam int unsigned OP_ARG_W = 16;

  localparam logic [OP_CMD_W-1:0] OP_CMD_G00 = 8'h00;
  localparam logic [OP_CMD_W-1:0] OP_CMD_G01 = 8'h01;
  localparam logic [OP_CMD_W-1:0] OP_CMD_G02 = 8'h02;
  localparam logic [OP_CMD_W-1:0] OP_CMD_G03 = 8'h03;
  localparam logic [OP_CMD_W-1:0] OP_CMD_G90 = 8'h5A;
  localparam logic [OP_CMD_W-1:0] OP_CMD_G91 = 8'h5B;
  localparam logic [OP_CMD_W-1:0] OP_CMD_M03 = 8'h83;
  localparam logic [OP_CMD_W-1:0] OP_CMD_M05 = 8'h85;

  typedef struct packed {
    logic [OP_CMD_W-1:0]        cmd;
    logic signed [OP_ARG_W-1:0] arg_1;
    logic signed [OP_ARG_W-1:0] arg_2;
  } Op_st;

  typedef enum logic [1:0] {
    DISP_IDLE,
    DISP_MODE,
    DISP_TRIG,
    DISP_WAIT_DONE
  } disp_state_e;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_LIN,
    SEL_CIRC,
    SEL_SERVO
  } handler_sel_e;

endpackage

// File: rtl/op_dispatcher_decoder.sv
// OpCmdDecoder: combinational command decode into handler select, mode
// (G90/G91) and unknown-command flags.
module OpCmdDecoder
  import Op_PKG::*;
(
  input  logic [OP_CMD_W-1:0] cmd,
  output handler_sel_e        sel,
  output logic                is_mode,
  output logic                unknown
);

  always_comb begin
    sel     = SEL_NONE;
    is_mode = 1'b0;
    unknown = 1'b0;
    case (cmd)
      OP_CMD_G00, OP_CMD_G01: sel = SEL_LIN;
      OP_CMD_G02, OP_CMD_G03: sel = SEL_CIRC;
      OP_CMD_M03, OP_CMD_M05: sel = SEL_SERVO;
      OP_CMD_G90, OP_CMD_G91: is_mode = 1'b1;
      default:                unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/op_dispatcher.sv
// op_dispatcher: accepts ops from the parser and triggers one handler per op.
// Optional handler watchdog enabled by defining OP_DISPATCHER_TIMEOUT_EN.
module op_dispatcher
  import Op_PKG::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  input  Op_st in_op,
  input  logic in_valid,
  output logic in_rdy,
  output Op_st op,
  output logic lin_trigger,
  output logic circ_trigger,
  output logic servo_trigger,
  input  logic lin_rdy,
  input  logic circ_rdy,
  input  logic servo_rdy,
  output logic err_unknown,
  output logic err_timeout
);

  disp_state_e  state, state_nxt;
  handler_sel_e sel;
  handler_sel_e dec_sel;
  logic         dec_mode;
  logic         dec_unknown;
  logic         accept;
  logic         sel_rdy;
  logic         timeout;
  logic         timeout_hit;

  OpCmdDecoder u_decoder (
    .cmd     (in_op.cmd),
    .sel     (dec_sel),
    .is_mode (dec_mode),
    .unknown (dec_unknown)
  );

  // Only the selected handler's rdy is ever observed.
  always_comb begin
    sel_rdy = 1'b0;
    case (sel)
      SEL_LIN:   sel_rdy = lin_rdy;
      SEL_CIRC:  sel_rdy = circ_rdy;
      SEL_SERVO: sel_rdy = servo_rdy;
      default:   sel_rdy = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      DISP_IDLE: begin
        if (in_valid) begin
          accept = 1'b1;
          if (dec_mode)
            state_nxt = DISP_MODE;
          else if (dec_sel != SEL_NONE)
            state_nxt = DISP_TRIG;
        end
      end
      DISP_MODE: state_nxt = DISP_IDLE;
      DISP_TRIG: begin
        if (!sel_rdy) begin
          state_nxt = DISP_WAIT_DONE;
        end else if (timeout) begin
          state_nxt   = DISP_IDLE;
          timeout_hit = 1'b1;
        end
      end
      DISP_WAIT_DONE: begin
        if (sel_rdy) begin
          state_nxt = DISP_IDLE;
        end else if (timeout) begin
          state_nxt   = DISP_IDLE;
          timeout_hit = 1'b1;
        end
      end
      default: state_nxt = DISP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= DISP_IDLE;
      sel         <= SEL_NONE;
      op          <= '0;
      err_unknown <= 1'b0;
    end else if (clk_en) begin
      state <= state_nxt;
      if (accept) begin
        op  <= in_op;
        sel <= dec_sel;
        if (dec_unknown)
          err_unknown <= 1'b1;
      end
    end
  end

`ifdef OP_DISPATCHER_TIMEOUT_EN
  logic [31:0] wd_cnt;

  // Counter sits at zero outside TRIG/WAIT_DONE, so it is clear on TRIG entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else if (clk_en) begin
      if (state == DISP_TRIG || state == DISP_WAIT_DONE)
        wd_cnt <= wd_cnt + 32'd1;
      else
        wd_cnt <= '0;
      if (timeout_hit)
        err_timeout <= 1'b1;
    end
  end

  assign timeout = (wd_cnt == TIMEOUT_CYCLES - 32'd1);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, timeout_hit};
  assign timeout            = 1'b0;
  assign err_timeout        = 1'b0;
`endif

  assign in_rdy        = (state == DISP_IDLE);
  assign lin_trigger   = (state == DISP_TRIG) && (sel == SEL_LIN);
  assign circ_trigger  = (state == DISP_TRIG) && (sel == SEL_CIRC);
  assign servo_trigger = (state == DISP_TRIG) && (sel == SEL_SERVO);

endmodule
